uart_tx_fifo: RTL

Byte buffer between the memory-mapped UART data register and the `uart` transmitter. Accepts single-cycle write strobes from `memory_map` at CPU speed, stores up to `DEPTH` bytes, and drains them one at a time into `uart` using its `tx_req`/`tx_busy` handshake. Software can then emit short strings without polling per byte. Exposes full, empty, level and a sticky overflow flag for the status register.

---
 rtl/uart_fifo_pkg.sv | 12 +
 rtl/sync_fifo.sv | 83 ++++++++
 rtl/uart_tx_fifo.sv | 95 +++++++++
 3 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared types for the UART transmit buffer: drain FSM states and byte width.
package uart_fifo_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    WAIT  = 2'd2
  } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular buffer with a separate occupancy counter, registered
// full/empty flags and a synchronous flush that empties it in one edge.
module sync_fifo
  import uart_fifo_pkg::*;
#(
  parameter  int WIDTH  = DATA_W,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              do_push;
  logic              do_pop;

  // Flush outranks both a push and a pop presented on the same edge.
  always_comb begin
    do_push  = push && !full_q && !flush;
    do_pop   = pop && !empty_q && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + (ADDR_W+1)'(1);
        2'b01:   level_d = level_q - (ADDR_W+1)'(1);
        default: level_d = level_q;
      endcase
    end
    full_d  = (level_d == FULL_LEVEL);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign level   = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer between the CPU-side UART data register and the transmitter:
// buffers pushes and drains them one frame at a time over tx_req/tx_busy.
module uart_tx_fifo
  import uart_fifo_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_req,
  input  logic              flush,
  input  logic              ovf_clear,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_req,
  input  logic              tx_busy
);

  drain_state_t      state_q, state_d;
  logic              tx_req_q, tx_req_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              overflow_q, overflow_d;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_rd_data;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .push    (wr_req),
    .pop     (fifo_pop),
    .wr_data (wr_data),
    .rd_data (fifo_rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_comb begin
    state_d    = state_q;
    tx_req_d   = 1'b0;
    tx_data_d  = tx_data_q;
    fifo_pop   = 1'b0;
    overflow_d = overflow_q;

    // A drop is judged on the pre-edge full flag; a flushed push is not a drop.
    if (wr_req && full && !flush) begin
      overflow_d = 1'b1;
    end else if (ovf_clear) begin
      overflow_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!empty && !flush) begin
          fifo_pop  = 1'b1;
          tx_req_d  = 1'b1;
          tx_data_d = fifo_rd_data;
          state_d   = GUARD;
        end
      end
      // The uart raises busy a cycle after the request, so busy is not trusted here.
      GUARD:   state_d = WAIT;
      WAIT:    if (!tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_req_q   <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_req_q   <= tx_req_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_req   = tx_req_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;

endmodule
